rs_encode_block_padder: RTL and testbench
=========================================

// Module: rs_encode_block_padder
// PURPOSE
//  Upstream feeder for the RS stream encoder. Takes a request length in bytes and a dense byte stream.
//  Emits the encoder request (num_blocks = ceil(len/RS_K)), then the data regrouped into RS_K-byte blocks.
//  Each block is NUM_LINES lines; the tail of every line past the block's (or request's) last byte is zero.
// PARAMETERS
//  NUM_REQ_BLOCKS    -1              max blocks per request
//  NUM_REQ_BLOCKS_W  -1              width of block count
//  DATA_W            -1              line width, bits (multiple of 8)
//  DATA_BYTES        DATA_W/8        bytes per line
//  LEN_W             -1              width of request byte length
// PORTS
//  clk                                    in   1           clock
//  rst                                    in   1           async active-high reset
//  src_block_padder_req_val               in   1           request valid
//  src_block_padder_req_len               in   LEN_W       request length, bytes
//  block_padder_src_req_rdy               out  1           request accepted
//  src_block_padder_data_val              in   1           input line valid
//  src_block_padder_data                  in   DATA_W      input line, byte 0 at [DATA_W-1-:8]
//  src_block_padder_data_last             in   1           final input line of request
//  block_padder_src_data_rdy              out  1           input line accepted
//  block_padder_encoder_req_val           out  1           encoder request valid
//  block_padder_encoder_req_num_blocks    out  NUM_REQ_BLOCKS_W  blocks in request
//  encoder_block_padder_req_rdy           in   1           encoder request ready
//  block_padder_encoder_data_val          out  1           output line valid
//  block_padder_encoder_data              out  DATA_W      output line, byte 0 at MSB
//  encoder_block_padder_data_rdy          in   1           output line ready
// BEHAVIOUR
//  Reset: every *_val and *_rdy output is 0. num_blocks and data are 0. FSM is IDLE. Buffer count is 0.
//  Reset is honoured mid-request: all in-flight bytes are discarded.
//  Handshake: a transfer occurs on val&rdy. val, once raised, holds with stable payload until the transfer.
//  FSM:
//  - IDLE: req_rdy=1. On accept, latch len, clear blk_cnt, go to CALC.
//  - CALC: one cycle per iteration, remaining -= RS_K and blk_cnt++ while remaining > 0.
//    Latency is num_blocks cycles; no divider. Then go to REQ.
//  - REQ: encoder_req_val=1. On handshake, go to DATA.
//  - DATA: the gearbox moves bytes (below). After the last line of the last block, go to IDLE.
//    Next req_rdy is 1 the cycle after that.
//  Gearbox: byte buffer of 2*DATA_BYTES bytes, buf_cnt 0..2*DATA_BYTES.
//  - in_left = bytes not yet consumed from input. blk_pos = byte offset within the current block.
//  - need = min(DATA_BYTES, RS_K - blk_pos).
//  - src_data_rdy = DATA && in_left > 0 && buf_cnt <= DATA_BYTES.
//    Each accepted line adds min(DATA_BYTES, in_left) bytes; excess bytes in the final line are dropped.
//  - Output line is valid when buf_cnt >= need, or when in_left == 0 and a block line remains.
//    Line takes min(need, buf_cnt) buffer bytes and is zero-filled to DATA_W.
//    On emit, shift the buffer by the bytes taken, blk_pos += need, wrap blk_pos to 0 at RS_K.
//  - Total emitted lines = num_blocks*NUM_LINES. Lines after input exhaustion are all zero.
//  - Same-cycle accept and emit is legal: new buf_cnt = buf_cnt + added - taken.
//  Boundaries:
//  - data_last must coincide with in_left reaching 0; mismatch is a sim assertion error, and input is ignored.
//  - len == 0 or len > NUM_REQ_BLOCKS*RS_K is illegal (assertion); no output is produced, return to IDLE.
//  - A second req_val during DATA is not accepted until IDLE.
//  - blk_pos and blk_cnt arithmetic is carry-free; widths are $clog2(RS_K+1) and NUM_REQ_BLOCKS_W.
// STRUCTURE
//  rs_encode_pkg gains the following (the encoder stream wrap also uses the package NUM_LINES):
//  - RS_NUM_LINES(data_bytes) function
//  - RS_LAST_LINE_BYTES(data_bytes) function
//  - padder state enum
//  Sub-module rs_pad_gearbox: byte buffer, shift/merge, zero-fill. FSM and counters stay in the top.
// TESTING (RS_K=223, DATA_W=256: NUM_LINES=7, input byte i = (i+1)%256)
//  1 len=223 -> num_blocks=1, 7 lines; line6 bytes0..30 = 0xC1..0xDF, byte31=0.
//  2 len=446 -> num_blocks=2, 14 lines; line7 byte0=0xE0; line13 byte30=0xBE, byte31=0.
//  3 len=1 -> num_blocks=1; line0 = 0x01 then zeros; lines1..6 all zero.
//  4 len=500, 50% random stalls on both rdy and src val -> num_blocks=3, 21 lines, match stall-free golden.
//  5 rst pulsed mid-DATA of len=446 -> vals drop asynchronously; next req len=223 gives case-1 output exactly.
//  6 back-to-back reqs 223 then 224 -> no byte leakage; 2nd num_blocks=2, line7 byte0=0xE0, rest of block zero.

Source files
------------

// File: rtl/rs_encode_pkg.sv
// rtl/rs_encode_pkg.sv - shared RS encoder constants, line geometry helpers and padder state
package rs_encode_pkg;

  localparam int RS_K = 223;

  function automatic int RS_NUM_LINES(input int data_bytes);
    return (RS_K + data_bytes - 1) / data_bytes;
  endfunction

  // Bytes of the final line of a block that carry codeword data.
  function automatic int RS_LAST_LINE_BYTES(input int data_bytes);
    return RS_K - (RS_NUM_LINES(data_bytes) - 1) * data_bytes;
  endfunction

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_CALC,
    PAD_REQ,
    PAD_DATA
  } pad_state_e;

endpackage

// File: rtl/rs_pad_gearbox.sv
// rtl/rs_pad_gearbox.sv - two-line byte buffer with take/append shift and zero-filled output line
module rs_pad_gearbox #(
  parameter int DATA_W     = 256,
  parameter int DATA_BYTES = DATA_W / 8,
  parameter int CNT_W      = $clog2(2 * DATA_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              add_en_i,
  input  logic [CNT_W-1:0]  add_cnt_i,
  input  logic [DATA_W-1:0] add_data_i,
  input  logic              take_en_i,
  input  logic [CNT_W-1:0]  take_cnt_i,
  output logic [DATA_W-1:0] line_o,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam int BUF_W = 2 * DATA_W;

  // Bytes at or beyond cnt_q are always zero, so appends merge with a plain OR.
  logic [BUF_W-1:0]  bytes_q, bytes_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  taken;
  logic [CNT_W-1:0]  cnt_kept;
  logic [BUF_W-1:0]  kept;
  logic [BUF_W-1:0]  placed;
  logic [DATA_W-1:0] add_line;

  function automatic logic [DATA_W-1:0] byte_mask(input logic [CNT_W-1:0] n);
    byte_mask = ~({DATA_W{1'b1}} >> (int'(n) * 8));
  endfunction

  always_comb begin
    taken    = take_en_i ? take_cnt_i : '0;
    cnt_kept = cnt_q - taken;
    kept     = bytes_q << (int'(taken) * 8);
    add_line = add_data_i & byte_mask(add_cnt_i);
    placed   = add_en_i ? ({add_line, {DATA_W{1'b0}}} >> (int'(cnt_kept) * 8)) : '0;
    bytes_d  = kept | placed;
    cnt_d    = cnt_kept + (add_en_i ? add_cnt_i : '0);
    if (clr_i) begin
      bytes_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bytes_q <= '0;
      cnt_q   <= '0;
    end else begin
      bytes_q <= bytes_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_o = bytes_q[BUF_W-1 -: DATA_W] & byte_mask(take_cnt_i);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/rs_encode_block_padder.sv
// rtl/rs_encode_block_padder.sv - splits a byte-length request into zero-padded RS_K-byte blocks for the encoder
module rs_encode_block_padder
  import rs_encode_pkg::*;
#(
  parameter int NUM_REQ_BLOCKS   = 4,
  parameter int NUM_REQ_BLOCKS_W = 3,
  parameter int DATA_W           = 256,
  parameter int DATA_BYTES       = DATA_W / 8,
  parameter int LEN_W            = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        src_block_padder_req_val,
  input  logic [LEN_W-1:0]            src_block_padder_req_len,
  output logic                        block_padder_src_req_rdy,
  input  logic                        src_block_padder_data_val,
  input  logic [DATA_W-1:0]           src_block_padder_data,
  input  logic                        src_block_padder_data_last,
  output logic                        block_padder_src_data_rdy,
  output logic                        block_padder_encoder_req_val,
  output logic [NUM_REQ_BLOCKS_W-1:0] block_padder_encoder_req_num_blocks,
  input  logic                        encoder_block_padder_req_rdy,
  output logic                        block_padder_encoder_data_val,
  output logic [DATA_W-1:0]           block_padder_encoder_data,
  input  logic                        encoder_block_padder_data_rdy
);

  localparam int CNT_W           = $clog2(2 * DATA_BYTES + 1);
  localparam int POS_W           = $clog2(RS_K + 1);
  localparam int LAST_LINE_BYTES = RS_LAST_LINE_BYTES(DATA_BYTES);

  pad_state_e                  state_q, state_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [LEN_W-1:0]            rem_q, rem_d;
  logic [LEN_W-1:0]            in_left_q, in_left_d;
  logic [NUM_REQ_BLOCKS_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [NUM_REQ_BLOCKS_W-1:0] blk_left_q, blk_left_d;
  logic [POS_W-1:0]            blk_pos_q, blk_pos_d;
  logic                        req_rdy_q, req_rdy_d;

  logic [CNT_W-1:0]  buf_cnt;
  logic [DATA_W-1:0] gb_line;
  logic [POS_W-1:0]  blk_room;
  logic [POS_W-1:0]  pos_next;
  logic [CNT_W-1:0]  need;
  logic [CNT_W-1:0]  add_cnt;
  logic [CNT_W-1:0]  take_cnt;
  logic              req_acc, req_legal;
  logic              src_rdy, src_acc;
  logic              out_val, emit, blk_end;

  always_comb begin
    blk_room  = POS_W'(RS_K) - blk_pos_q;
    need      = (blk_room > POS_W'(DATA_BYTES)) ? CNT_W'(DATA_BYTES) : CNT_W'(blk_room);
    add_cnt   = (in_left_q > LEN_W'(DATA_BYTES)) ? CNT_W'(DATA_BYTES) : CNT_W'(in_left_q);
    take_cnt  = (buf_cnt >= need) ? need : buf_cnt;
    pos_next  = blk_pos_q + POS_W'(need);
    blk_end   = (pos_next == POS_W'(RS_K));
    req_legal = (src_block_padder_req_len != '0) &&
                (32'(src_block_padder_req_len) <= 32'(NUM_REQ_BLOCKS * RS_K));
    req_acc   = (state_q == PAD_IDLE) && req_rdy_q && src_block_padder_req_val;
    src_rdy   = (state_q == PAD_DATA) && (in_left_q != '0) && (buf_cnt <= CNT_W'(DATA_BYTES));
    src_acc   = src_rdy && src_block_padder_data_val;
    // Once input is exhausted every remaining block line is released, zero-filled.
    out_val   = (state_q == PAD_DATA) && ((buf_cnt >= need) || (in_left_q == '0));
    emit      = out_val && encoder_block_padder_data_rdy;
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rem_d      = rem_q;
    in_left_d  = in_left_q;
    blk_cnt_d  = blk_cnt_q;
    blk_left_d = blk_left_q;
    blk_pos_d  = blk_pos_q;
    case (state_q)
      PAD_IDLE: begin
        if (req_acc && req_legal) begin
          len_d     = src_block_padder_req_len;
          rem_d     = src_block_padder_req_len;
          blk_cnt_d = '0;
          state_d   = PAD_CALC;
        end
      end
      PAD_CALC: begin
        blk_cnt_d = blk_cnt_q + 1'b1;
        if (rem_q <= LEN_W'(RS_K)) state_d = PAD_REQ;
        else                       rem_d   = rem_q - LEN_W'(RS_K);
      end
      PAD_REQ: begin
        if (encoder_block_padder_req_rdy) begin
          in_left_d  = len_q;
          blk_left_d = blk_cnt_q;
          blk_pos_d  = '0;
          state_d    = PAD_DATA;
        end
      end
      PAD_DATA: begin
        if (src_acc) in_left_d = in_left_q - LEN_W'(add_cnt);
        if (emit) begin
          blk_pos_d = blk_end ? '0 : pos_next;
          if (blk_end) begin
            blk_left_d = blk_left_q - 1'b1;
            if (blk_left_q == NUM_REQ_BLOCKS_W'(1)) state_d = PAD_IDLE;
          end
        end
      end
      default: state_d = PAD_IDLE;
    endcase
    req_rdy_d = (state_d == PAD_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PAD_IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      in_left_q  <= '0;
      blk_cnt_q  <= '0;
      blk_left_q <= '0;
      blk_pos_q  <= '0;
      req_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      in_left_q  <= in_left_d;
      blk_cnt_q  <= blk_cnt_d;
      blk_left_q <= blk_left_d;
      blk_pos_q  <= blk_pos_d;
      req_rdy_q  <= req_rdy_d;
    end
  end

  rs_pad_gearbox #(
    .DATA_W     (DATA_W),
    .DATA_BYTES (DATA_BYTES),
    .CNT_W      (CNT_W)
  ) u_gearbox (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == PAD_IDLE),
    .add_en_i   (src_acc),
    .add_cnt_i  (add_cnt),
    .add_data_i (src_block_padder_data),
    .take_en_i  (emit),
    .take_cnt_i (take_cnt),
    .line_o     (gb_line),
    .cnt_o      (buf_cnt)
  );

  assign block_padder_src_req_rdy            = req_rdy_q;
  assign block_padder_src_data_rdy           = src_rdy;
  assign block_padder_encoder_req_val        = (state_q == PAD_REQ);
  assign block_padder_encoder_req_num_blocks = blk_cnt_q;
  assign block_padder_encoder_data_val       = out_val;
  assign block_padder_encoder_data           = out_val ? gb_line : '0;

  a_req_len_legal: assert property (@(posedge clk) disable iff (rst) req_acc |-> req_legal);
  a_last_aligned: assert property (@(posedge clk) disable iff (rst)
    src_acc |-> (src_block_padder_data_last == (in_left_q <= LEN_W'(DATA_BYTES))));
  a_tail_line: assert property (@(posedge clk) disable iff (rst)
    (emit && blk_end) |-> (need == CNT_W'(LAST_LINE_BYTES)));

endmodule

// File: tb/tb_rs_encode_block_padder.sv
// tb/tb_rs_encode_block_padder.sv - directed table-driven bench for rs_encode_block_padder
module tb_rs_encode_block_padder;

  localparam int DW = 256;
  localparam int DB = 32;
  localparam int K  = 223;
  localparam int NL = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_val = 1'b0;
  logic [10:0]   req_len = '0;
  logic          req_rdy;
  logic          src_val = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_last = 1'b0;
  logic          src_rdy;
  logic          enc_req_val;
  logic [2:0]    num_blocks;
  logic          enc_req_rdy = 1'b0;
  logic          enc_data_val;
  logic [DW-1:0] enc_data;
  logic          enc_data_rdy = 1'b0;

  int            checks = 0;
  int            errors = 0;
  bit            sink_done;
  logic [DW-1:0] got[$];

  typedef struct {
    int len;
    int exp_nb;
    bit stall;
  } vec_t;

  always #5 clk = ~clk;

  rs_encode_block_padder #(
    .NUM_REQ_BLOCKS   (4),
    .NUM_REQ_BLOCKS_W (3),
    .DATA_W           (DW),
    .LEN_W            (11)
  ) dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .src_block_padder_req_val            (req_val),
    .src_block_padder_req_len            (req_len),
    .block_padder_src_req_rdy            (req_rdy),
    .src_block_padder_data_val           (src_val),
    .src_block_padder_data               (src_data),
    .src_block_padder_data_last          (src_last),
    .block_padder_src_data_rdy           (src_rdy),
    .block_padder_encoder_req_val        (enc_req_val),
    .block_padder_encoder_req_num_blocks (num_blocks),
    .encoder_block_padder_req_rdy        (enc_req_rdy),
    .block_padder_encoder_data_val       (enc_data_val),
    .block_padder_encoder_data           (enc_data),
    .encoder_block_padder_data_rdy       (enc_data_rdy)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte i of a request is (i+1)%256; bytes past the request length are junk the DUT must drop.
  function automatic logic [DW-1:0] src_line(input int len, input int k);
    logic [DW-1:0] r;
    int p;
    r = '0;
    for (int j = 0; j < DB; j++) begin
      p = k * DB + j;
      r[DW-1-8*j -: 8] = (p < len) ? 8'((p + 1) % 256) : 8'hAA;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_line(input int len, input int b, input int l);
    logic [DW-1:0] r;
    int pb, p;
    r = '0;
    for (int j = 0; j < DB; j++) begin
      pb = l * DB + j;
      p  = b * K + pb;
      r[DW-1-8*j -: 8] = (pb < K && p < len) ? 8'((p + 1) % 256) : 8'h00;
    end
    return r;
  endfunction

  task automatic run_req(input int len, input int exp_nb, input bit stall, input int stop_after);
    int  lat;
    bit  ok;
    int  nin;
    int  target;
    got.delete();
    nin    = (len + DB - 1) / DB;
    target = (stop_after < exp_nb * NL) ? stop_after : exp_nb * NL;

    @(posedge clk); #1;
    req_val = 1'b1;
    req_len = 11'(len);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_rdy) begin ok = 1'b1; break; end
    end
    chk("req_accept", ok, 1);
    @(posedge clk); #1;
    req_val = 1'b0;
    req_len = '0;

    enc_req_rdy = !stall;
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lat++;
      if (enc_req_val) begin ok = 1'b1; break; end
    end
    chk("enc_req_val", ok, 1);
    chk("calc_latency", lat, exp_nb + 1);
    chk("num_blocks", num_blocks, exp_nb);
    if (stall) begin
      repeat (3) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("enc_req_hold", {enc_req_val, num_blocks}, {1'b1, 3'(exp_nb)});
      end
      @(posedge clk); #1;
      enc_req_rdy = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    enc_req_rdy = 1'b0;

    sink_done = 1'b0;
    fork
      begin
        int  k;
        int  cyc;
        bit  fired;
        k   = 0;
        cyc = 0;
        while (k < nin && !sink_done && cyc < 5000) begin
          if (!src_val) src_val = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          src_data = src_line(len, k);
          src_last = (k == nin - 1);
          @(negedge clk);
          fired = src_val && src_rdy;
          if (fired) k++;
          @(posedge clk); #1;
          if (fired) src_val = 1'b0;
          cyc++;
        end
        src_val  = 1'b0;
        src_last = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (got.size() < target && cyc < 5000) begin
          enc_data_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          @(negedge clk);
          if (enc_data_val && enc_data_rdy) got.push_back(enc_data);
          @(posedge clk); #1;
          cyc++;
        end
        enc_data_rdy = 1'b0;
        sink_done    = 1'b1;
      end
    join

    chk($sformatf("len%0d_line_count", len), got.size(), target);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("len%0d_line%0d", len, i), got[i], exp_line(len, i / NL, i % NL));
    if (target == exp_nb * NL) begin
      @(negedge clk);
      chk("idle_after_last_line", {req_rdy, src_rdy, enc_data_val, enc_req_val}, 4'b1000);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 223, exp_nb: 1, stall: 1'b0};
    vecs[1] = '{len: 446, exp_nb: 2, stall: 1'b0};
    vecs[2] = '{len: 1,   exp_nb: 1, stall: 1'b0};
    vecs[3] = '{len: 500, exp_nb: 3, stall: 1'b1};
    vecs[4] = '{len: 32,  exp_nb: 1, stall: 1'b0};
    vecs[5] = '{len: 224, exp_nb: 2, stall: 1'b1};
    vecs[6] = '{len: 892, exp_nb: 4, stall: 1'b0};

    #3;
    chk("reset_outputs", {req_rdy, src_rdy, enc_req_val, enc_data_val, num_blocks}, 7'b0);
    chk("reset_data", enc_data, '0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].len, vecs[i].exp_nb, vecs[i].stall, 1000);
      if (vecs[i].len == 446) begin
        chk("c2_line7_byte0", got[7][DW-1 -: 8], 8'hE0);
        chk("c2_line13_byte30", got[13][15:8], 8'hBE);
        chk("c2_line13_byte31", got[13][7:0], 8'h00);
      end
      if (vecs[i].len == 1) begin
        chk("c3_line0", got[0], {8'h01, 248'h0});
        chk("c3_line6", got[6], '0);
      end
    end

    // Reset mid-DATA, then a clean request must match the single-block golden exactly.
    run_req(446, 2, 1'b0, 5);
    #2;
    chk("active_before_rst", enc_data_val || src_rdy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_vals", {req_rdy, src_rdy, enc_req_val, enc_data_val}, 4'b0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    run_req(223, 1, 1'b0, 1000);
    chk("c5_line6_byte0", got[6][DW-1 -: 8], 8'hC1);
    chk("c5_line6_byte30", got[6][15:8], 8'hDF);
    chk("c5_line6_byte31", got[6][7:0], 8'h00);

    // Back-to-back requests: nothing from the first may leak into the second.
    run_req(223, 1, 1'b0, 1000);
    run_req(224, 2, 1'b0, 1000);
    chk("c6_line7_byte0", got[7][DW-1 -: 8], 8'hE0);
    chk("c6_line7_rest", got[7][DW-9:0], '0);
    chk("c6_line8", got[8], '0);
    chk("c6_line13", got[13], '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
